// File: rtl/mul_pkg.sv
// Shared types and sizing for the shift-add multiplier.
// The ZERO_BYPASS_EN build option lives in shift_add_multiplier.sv.
package mul_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int last_iter(input int width);
        return width - 1;
    endfunction

    localparam int LAST_ITER = last_iter(WIDTH_DEFAULT);

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake bundle between a requester (master) and the multiplier (slave).
// The ZERO_BYPASS_EN build option does not change this interface.
interface shift_add_multiplier_if
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );

endinterface

// File: rtl/shift_add_multiplier_adder.sv
// Combinational WIDTH-bit ripple-carry adder built from full-adder cells.
// The ZERO_BYPASS_EN build option does not affect this block.
module ripple_adder_w
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]       = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one add-and-shift per cycle.
// Define ZERO_BYPASS_EN to finish immediately when either operand is zero.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_add_multiplier_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(last_iter(WIDTH));

    state_e               state_q,   state_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]     acc_q,     acc_d;
    logic [WIDTH-1:0]     mplr_q,    mplr_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic [2*WIDTH-1:0]   shift_val;

    assign addend = mplr_q[0] ? mcand_q : '0;

    ripple_adder_w #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x    (acc_q),
        .y    (addend),
        .cin  (1'b0),
        .s    (add_sum),
        .cout (add_cout)
    );

    // {carry, sum, mplr} >> 1: the carry lands in the top bit of acc, never lost.
    assign shift_val = {add_cout, add_sum, mplr_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef ZERO_BYPASS_EN
                    if ((bus.a == '0) || (bus.b == '0)) begin
                        product_d = '0;
                        state_d   = DONE;
                    end else begin
                        mcand_d = bus.a;
                        acc_d   = '0;
                        mplr_d  = bus.b;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
`else
                    mcand_d = bus.a;
                    acc_d   = '0;
                    mplr_d  = bus.b;
                    cnt_d   = '0;
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                {acc_d, mplr_d} = shift_val;
                cnt_d           = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    product_d = shift_val;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (honours ZERO_BYPASS_EN if defined).
module tb_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    shift_add_multiplier_if #(.WIDTH(32)) bus ();

    shift_add_multiplier #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One start pulse, then sample #1 after each edge until done; k counts edges after acceptance.
    task automatic do_mul(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                          input bit scramble, output int done_k, output int busy_n,
                          output logic [63:0] prod);
        logic [63:0] prev;
        bit          stable;
        bit          seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = aa;
        bus.b     = bb;
        prev      = bus.product;
        stable    = 1'b1;
        seen      = 1'b0;
        busy_n    = 0;
        done_k    = -1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_k = k;
                seen   = 1'b1;
                break;
            end
            if (bus.product !== prev) stable = 1'b0;
            if (scramble) begin
                bus.a = $urandom;
                bus.b = $urandom;
            end
            @(posedge clk);
            #1;
        end
        prod = bus.product;
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " product_stable"}, 64'(stable), 64'd1);
        @(posedge clk);
        #1;
        check({tag, " ready_after"}, 64'(bus.ready), 64'd1);
    endtask

    initial begin
        int          dk;
        int          bn;
        logic [63:0] p;
        int          dones;
        int          first_k;
        int          second_k;
        int          rdy_k;
        int          acc_k;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset ready",   64'(bus.ready), 64'd1);
        check("reset busy",    64'(bus.busy),  64'd0);
        check("reset done",    64'(bus.done),  64'd0);
        check("reset product", bus.product,    64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_mul("basic", 32'd3, 32'd5, 1'b0, dk, bn, p);
        check("basic product", p, 64'h0000_0000_0000_000F);
        check("basic done_k",  64'(dk), 64'd32);
        check("basic busy_n",  64'(bn), 64'd32);

        do_mul("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, dk, bn, p);
        check("allones product", p, 64'hFFFF_FFFE_0000_0001);

        do_mul("msb", 32'h8000_0000, 32'd2, 1'b0, dk, bn, p);
        check("msb product", p, 64'h0000_0001_0000_0000);

        do_mul("mixed", 32'd12345, 32'd6789, 1'b0, dk, bn, p);
        check("mixed product", p, 64'd83810205);

        // start held high: second acceptance must land on the first ready edge
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd7;
        bus.b     = 32'd9;
        @(posedge clk);
        #1;
        dones    = 0;
        first_k  = -1;
        second_k = -1;
        rdy_k    = -1;
        acc_k    = -1;
        for (int k = 0; k < 68; k++) begin
            if (bus.done) begin
                dones++;
                if (first_k < 0) first_k = k;
                else if (second_k < 0) second_k = k;
            end
            if (bus.ready && rdy_k < 0) rdy_k = k;
            if (bus.busy && rdy_k >= 0 && acc_k < 0) acc_k = k;
            if (k == 66) bus.start = 1'b0;
            @(posedge clk);
            #1;
        end
        check("hs done_count", 64'(dones),    64'd2);
        check("hs first_done", 64'(first_k),  64'd32);
        check("hs second_done",64'(second_k), 64'd66);
        check("hs ready_k",    64'(rdy_k),    64'd33);
        check("hs accept_k",   64'(acc_k),    64'd34);
        check("hs product",    bus.product,   64'd63);

        do_mul("opchange", 32'd10, 32'd10, 1'b1, dk, bn, p);
        check("opchange product", p, 64'd100);
        bus.a = '0;
        bus.b = '0;

        // abort after iteration 10
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd123;
        bus.b     = 32'd456;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midrst busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst product", bus.product,    64'd0);
        check("midrst ready",   64'(bus.ready), 64'd1);
        check("midrst busy",    64'(bus.busy),  64'd0);
        dones = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("midrst no_done", 64'(dones), 64'd0);
        do_mul("after_rst", 32'd123, 32'd456, 1'b0, dk, bn, p);
        check("after_rst product", p, 64'd56088);
        check("after_rst done_k",  64'(dk), 64'd32);

        do_mul("zero", 32'd0, 32'hDEAD_BEEF, 1'b0, dk, bn, p);
        check("zero product", p, 64'd0);
`ifdef ZERO_BYPASS_EN
        check("zero done_k", 64'(dk), 64'd0);
        check("zero busy_n", 64'(bn), 64'd0);
`else
        check("zero done_k", 64'(dk), 64'd32);
        check("zero busy_n", 64'(bn), 64'd32);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier built on the team's ripple-carry adder.
- Sits downstream of the adder datapath and uses it once per cycle, in place of a large combinational array multiplier.
- Start/done handshake, one partial product per cycle, result held until the next accepted start.

Parameters:
- WIDTH, 32, operand width in bits; product width is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while ready=1.
- a  input  WIDTH  multiplicand; captured on an accepted start.
- b  input  WIDTH  multiplier; captured on an accepted start.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- product  output  2*WIDTH  result register; valid from done high until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; product=0; internal multiplicand, accumulator and counter = 0.
  - done=0, busy=0, ready=1.
  - Reset mid-operation aborts immediately; no partial result is retained.
- States:
  - IDLE: ready=1. start=1 at an edge loads mcand=a, {acc,mplr}={0,b}, cnt=0, and goes to RUN. Otherwise stays in IDLE.
  - RUN: busy=1. Each edge:
    - sum = acc + (mplr[0] ? mcand : 0), with carry_out, via the adder.
    - {acc,mplr} <= {carry_out, sum, mplr} >> 1.
    - cnt <= cnt+1.
    - After the WIDTH-th iteration (cnt==WIDTH-1 at the edge): product <= the shifted value, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start accepted at edge 0 -> product updated at edge WIDTH -> done high in the cycle after edge WIDTH -> ready high after edge WIDTH+1.
  - The earliest next accepted start is at edge WIDTH+2, i.e. the first edge at which ready=1.
- start while busy or in DONE is ignored (no queueing); operands on a/b in those cycles have no effect.
- product is stable through RUN and DONE and changes only at the final RUN edge or on reset.
- Arithmetic is unsigned. The 2*WIDTH result is exact; there is no overflow.
  - The adder carry_out is always captured into bit WIDTH-1 of acc after the shift and is never dropped.
- a and b may change freely after capture.

Optional Feature:
- Macro: ZERO_BYPASS_EN.
- Defined: an accepted start with a==0 or b==0 goes IDLE -> DONE directly. product<=0 at the accepting edge, done high the following cycle, busy never asserts.
- Undefined: all operands take the full WIDTH iterations; zero operands produce product=0 with normal latency.

Decomposition:
- Package mul_pkg holds:
  - WIDTH_DEFAULT=32 and CNT_W_DEFAULT=6.
  - State enum type (IDLE, RUN, DONE), 2-bit encoding.
  - Localparam LAST_ITER=WIDTH-1.
- One sub-module, ripple_adder_w: combinational WIDTH-bit ripple-carry adder with inputs x, y, cin and outputs s, cout, instantiated once with cin=0.
  - Built from the team's full-adder cells; no behavioural '+' in the datapath.

Test Plan:
- Basic: reset, then a=3, b=5, start one cycle -> done pulses in the cycle after edge 32; product=64'h0000_0000_0000_000F; busy high for exactly 32 cycles.
- Carry chain: a=b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001; a=32'h8000_0000, b=2 -> product=64'h0000_0001_0000_0000.
- Handshake: start held high continuously with a=7, b=9 -> first product=63. The start seen during RUN/DONE is ignored, and the next accepted start is exactly at the first edge ready=1 (edge 34); exactly one done per 34-cycle period.
- Operand change: a=10, b=10 accepted, then a/b toggled randomly during RUN -> product=100.
- Reset mid-op: start a=123, b=456, drop rst_n at iteration 10 -> product=0, ready=1, done never pulses; after release, a=123, b=456 -> product=56088.
- Zero bypass: a=0, b=32'hDEAD_BEEF -> with ZERO_BYPASS_EN, done in the cycle after the accepting edge and busy never high; without it, done after 32 iterations; product=0 in both cases.
